// File: rtl/midas_axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : midas_axi_pkg
//  Description : Shared AXI response codes, responder FSM states and default
//                widths for the DDR-port memory responder.
//  Revision    : 1.0  initial release
// ============================================================================
package midas_axi_pkg;

    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_DATA_WIDTH     = 64;
    localparam int DEF_ID_WIDTH       = 6;
    localparam int DEF_MEM_WORDS_LOG2 = 12;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        WRESP = 2'd2,
        RDATA = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/axi4_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_mem_responder_if
//  Description : AXI4 AW/W/B/AR/R channel bundle for the memory responder.
//  Revision    : 1.0  initial release
// ============================================================================
interface axi4_mem_responder_if
    import midas_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ID_WIDTH   = DEF_ID_WIDTH
);
    logic                    aw_valid;
    logic                    aw_ready;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [ID_WIDTH-1:0]     aw_id;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;

    logic                    w_valid;
    logic                    w_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;

    logic                    b_valid;
    logic                    b_ready;
    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;

    logic                    ar_valid;
    logic                    ar_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [ID_WIDTH-1:0]     ar_id;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;

    logic                    r_valid;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [ID_WIDTH-1:0]     r_id;
    logic [1:0]              r_resp;
    logic                    r_last;

    modport master (
        output aw_valid, aw_addr, aw_id, aw_len, aw_size, input aw_ready,
        output w_valid, w_data, w_strb, w_last, input w_ready,
        input  b_valid, b_id, b_resp, output b_ready,
        output ar_valid, ar_addr, ar_id, ar_len, ar_size, input ar_ready,
        input  r_valid, r_data, r_id, r_resp, r_last, output r_ready
    );

    modport slave (
        input  aw_valid, aw_addr, aw_id, aw_len, aw_size, output aw_ready,
        input  w_valid, w_data, w_strb, w_last, output w_ready,
        output b_valid, b_id, b_resp, input b_ready,
        input  ar_valid, ar_addr, ar_id, ar_len, ar_size, output ar_ready,
        output r_valid, r_data, r_id, r_resp, r_last, input r_ready
    );

endinterface
`default_nettype wire

// File: rtl/axi4_mem_responder_ram.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_mem_responder_ram
//  Description : 1R/1W synchronous RAM, per-byte write enable; read output
//                holds its value while the read enable is low.
//  Revision    : 1.0  initial release
// ============================================================================
module axi4_mem_responder_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_BITS  = 12
) (
    input  wire logic                    clock,
    input  wire logic [DATA_WIDTH/8-1:0] i_wr_strb,
    input  wire logic [ADDR_BITS-1:0]    i_wr_addr,
    input  wire logic [DATA_WIDTH-1:0]   i_wr_data,
    input  wire logic                    i_rd_en,
    input  wire logic [ADDR_BITS-1:0]    i_rd_addr,
    output logic      [DATA_WIDTH-1:0]   o_rd_data
);
    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_BITS)-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clock) begin
        for (int i = 0; i < DATA_WIDTH/8; i++) begin
            if (i_wr_strb[i]) begin
                r_mem[i_wr_addr][i*8 +: 8] <= i_wr_data[i*8 +: 8];
            end
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/axi4_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_mem_responder
//  Description : AXI4 slave memory model, INCR bursts, one transaction in
//                flight, fair AW/AR arbitration and ID-matched B/R responses.
//  Revision    : 1.0  initial release
// ============================================================================
module axi4_mem_responder
    import midas_axi_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ID_WIDTH       = DEF_ID_WIDTH,
    parameter int MEM_WORDS_LOG2 = DEF_MEM_WORDS_LOG2
) (
    input  wire logic           clock,
    input  wire logic           reset_n,
    axi4_mem_responder_if.slave axi
);
    localparam int                        c_OFFS      = $clog2(DATA_WIDTH/8);
    localparam logic [2:0]                c_BEAT_SIZE = 3'(c_OFFS);
    localparam logic [MEM_WORDS_LOG2-1:0] c_IDX_ONE   = MEM_WORDS_LOG2'(1);

    state_t                    r_state;
    logic                      r_read_last;
    logic                      r_err;
    logic                      r_rd_pending;
    logic [ID_WIDTH-1:0]       r_txn_id;
    logic [7:0]                r_len;
    logic [7:0]                r_beat;
    logic [MEM_WORDS_LOG2-1:0] r_idx;
    logic                      r_b_valid;
    logic [1:0]                r_b_resp;
    logic                      r_r_valid;
    logic [1:0]                r_r_resp;
    logic                      r_r_last;

    logic                      w_grant_w;
    logic                      w_grant_r;
    logic                      w_aw_fire;
    logic                      w_ar_fire;
    logic                      w_w_fire;
    logic                      w_r_fire;
    logic                      w_beat_end;
    logic                      w_last_bad;
    logic                      w_rd_en;
    logic [DATA_WIDTH/8-1:0]   w_we;
    logic [DATA_WIDTH-1:0]     w_ram_q;
    logic [ADDR_WIDTH-1:0]     w_unused_addr;

    // Tie-break favours whichever channel was not served last.
    assign w_grant_w = axi.aw_valid & (~axi.ar_valid | r_read_last);
    assign w_grant_r = axi.ar_valid & ~w_grant_w;

    assign axi.aw_ready = reset_n & (r_state == IDLE) & w_grant_w;
    assign axi.ar_ready = reset_n & (r_state == IDLE) & w_grant_r;
    assign axi.w_ready  = reset_n & (r_state == WDATA);

    assign w_aw_fire  = axi.aw_valid & axi.aw_ready;
    assign w_ar_fire  = axi.ar_valid & axi.ar_ready;
    assign w_w_fire   = axi.w_valid & axi.w_ready;
    assign w_r_fire   = r_r_valid & axi.r_ready;
    assign w_beat_end = (r_beat == r_len);
    assign w_last_bad = axi.w_last ^ w_beat_end;
    assign w_we       = (w_w_fire && !r_err) ? axi.w_strb : '0;
    assign w_rd_en    = (r_state == RDATA) & r_rd_pending & (~r_r_valid | axi.r_ready);

    // Only the word-index bits of the addresses matter to this model.
    assign w_unused_addr = axi.aw_addr ^ axi.ar_addr;

    assign axi.b_valid = r_b_valid;
    assign axi.b_resp  = r_b_resp;
    assign axi.b_id    = r_txn_id;
    assign axi.r_valid = r_r_valid;
    assign axi.r_resp  = r_r_resp;
    assign axi.r_last  = r_r_last;
    assign axi.r_id    = r_txn_id;
    assign axi.r_data  = (r_r_valid && !r_err) ? w_ram_q : '0;

    axi4_mem_responder_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (MEM_WORDS_LOG2)
    ) u_ram (
        .clock      (clock),
        .i_wr_strb  (w_we),
        .i_wr_addr  (r_idx),
        .i_wr_data  (axi.w_data),
        .i_rd_en    (w_rd_en),
        .i_rd_addr  (r_idx),
        .o_rd_data  (w_ram_q)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_read_last  <= 1'b1;
            r_err        <= 1'b0;
            r_rd_pending <= 1'b0;
            r_txn_id     <= '0;
            r_len        <= '0;
            r_beat       <= '0;
            r_idx        <= '0;
            r_b_valid    <= 1'b0;
            r_b_resp     <= RESP_OKAY;
            r_r_valid    <= 1'b0;
            r_r_resp     <= RESP_OKAY;
            r_r_last     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_aw_fire) begin
                        r_txn_id    <= axi.aw_id;
                        r_len       <= axi.aw_len;
                        r_beat      <= '0;
                        r_idx       <= axi.aw_addr[MEM_WORDS_LOG2+c_OFFS-1:c_OFFS];
                        r_err       <= (axi.aw_size != c_BEAT_SIZE);
                        r_read_last <= 1'b0;
                        r_state     <= WDATA;
                    end else if (w_ar_fire) begin
                        r_txn_id     <= axi.ar_id;
                        r_len        <= axi.ar_len;
                        r_beat       <= '0;
                        r_idx        <= axi.ar_addr[MEM_WORDS_LOG2+c_OFFS-1:c_OFFS];
                        r_err        <= (axi.ar_size != c_BEAT_SIZE);
                        r_rd_pending <= 1'b1;
                        r_read_last  <= 1'b1;
                        r_state      <= RDATA;
                    end
                end
                WDATA: begin
                    if (w_w_fire) begin
                        r_idx <= r_idx + c_IDX_ONE;
                        if (w_last_bad) begin
                            r_err <= 1'b1;
                        end
                        if (w_beat_end) begin
                            r_b_valid <= 1'b1;
                            r_b_resp  <= (r_err | w_last_bad) ? RESP_SLVERR : RESP_OKAY;
                            r_state   <= WRESP;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                        end
                    end
                end
                WRESP: begin
                    if (axi.b_ready) begin
                        r_b_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                RDATA: begin
                    // r_beat counts beats issued to the RAM, one ahead of the bus.
                    if (w_rd_en) begin
                        r_idx     <= r_idx + c_IDX_ONE;
                        r_r_valid <= 1'b1;
                        r_r_last  <= w_beat_end;
                        r_r_resp  <= r_err ? RESP_SLVERR : RESP_OKAY;
                        if (w_beat_end) begin
                            r_rd_pending <= 1'b0;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                        end
                    end else if (w_r_fire) begin
                        r_r_valid <= 1'b0;
                    end
                    if (w_r_fire && r_r_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
